mem_ctrl: RTL and testbench

Byte-serialising memory controller inside `cpu`, directly upstream of the system byte bus (`mem_a`/`mem_wr`/`mem_dout`/`mem_din`) that feeds RAM and the HCI I/O window. It accepts word/halfword/byte requests from the instruction-fetch (IF) and load/store (LS) units, arbitrates between them, and turns each into a sequence of single-byte bus cycles. It also honours the `rdy_in` debug pause.

---
 rtl/mem_ctrl_if.sv | 32 +++
 rtl/mem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response and byte-bus signals of the memory controller.
//   IF port : if_req, if_addr -> if_rdata, if_done
//   LS port : ls_req, ls_we, ls_size, ls_addr, ls_wdata -> ls_rdata, ls_done
//   Byte bus: mem_din -> mem_a, mem_dout, mem_wr
// slave  = the controller side, master = the requesters plus the memory side.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
        output if_rdata, if_done, ls_rdata, ls_done, mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
        input  if_rdata, if_done, ls_rdata, ls_done, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serialising memory controller between the IF/LS units and
// the system byte bus. LS has fixed priority over IF. Each request becomes
// n single-byte bus cycles (n = 1/2/4), little-endian.
// Ports:
//   clk_in  - clock, all state on rising edge
//   rst_in  - asynchronous active-high reset
//   rdy_in  - bus ownership; low freezes the controller (HCI owns the bus)
//   bus     - mem_ctrl_if.slave: IF/LS request ports and the byte bus
module mem_ctrl (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic        port_ls;
    logic [31:0] base;
    logic [2:0]  nbytes;
    logic [31:0] wdata;
    logic [31:0] rbuf;
    logic [2:0]  issue_idx;
    logic [2:0]  cap_idx;
    logic        addr_vld_p0;   // a read address is on the bus this cycle
    logic        data_vld_p1;   // mem_din carries the byte for cap_idx this cycle
    logic        paused;        // previous edge was frozen by rdy_in=0
    logic [31:0] mem_a_r;
    logic [7:0]  mem_dout_r;
    logic        mem_wr_r;
    logic        if_done_r;
    logic        ls_done_r;
    logic [31:0] if_rdata_r;
    logic [31:0] ls_rdata_r;
    logic [31:0] req_addr;

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{k, 3'b000} +: 8] = b;
        return r;
    endfunction

    assign req_addr = bus.ls_req ? bus.ls_addr : bus.if_addr;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            port_ls     <= 1'b0;
            base        <= '0;
            nbytes      <= '0;
            wdata       <= '0;
            rbuf        <= '0;
            issue_idx   <= '0;
            cap_idx     <= '0;
            addr_vld_p0 <= 1'b0;
            data_vld_p1 <= 1'b0;
            paused      <= 1'b0;
            mem_a_r     <= '0;
            mem_dout_r  <= '0;
            mem_wr_r    <= 1'b0;
            if_done_r   <= 1'b0;
            ls_done_r   <= 1'b0;
            if_rdata_r  <= '0;
            ls_rdata_r  <= '0;
        end else begin
            paused <= ~rdy_in;
            if (rdy_in) begin
                case (state)
                    IDLE: begin
                        if (bus.ls_req || bus.if_req) begin
                            port_ls   <= bus.ls_req;
                            base      <= req_addr;
                            nbytes    <= bus.ls_req ? size_bytes(bus.ls_size) : 3'd4;
                            wdata     <= bus.ls_wdata;
                            rbuf      <= '0;
                            mem_a_r   <= req_addr;
                            issue_idx <= 3'd1;
                            cap_idx   <= 3'd0;
                            if (bus.ls_req && bus.ls_we) begin
                                state      <= WRITE;
                                mem_dout_r <= bus.ls_wdata[7:0];
                                mem_wr_r   <= 1'b1;
                            end else begin
                                state       <= READ;
                                addr_vld_p0 <= 1'b1;
                                data_vld_p1 <= 1'b0;
                            end
                        end
                    end
                    READ: begin
                        if (paused) begin
                            // HCI used the bus: re-drive the first uncaptured byte.
                            mem_a_r     <= base + {29'd0, cap_idx};
                            issue_idx   <= cap_idx + 3'd1;
                            addr_vld_p0 <= 1'b1;
                            data_vld_p1 <= 1'b0;
                        end else begin
                            // ---- stage p0 -> p1: address issued last cycle, data now on mem_din
                            data_vld_p1 <= addr_vld_p0;
                            if (issue_idx < nbytes) begin
                                mem_a_r     <= base + {29'd0, issue_idx};
                                issue_idx   <= issue_idx + 3'd1;
                                addr_vld_p0 <= 1'b1;
                            end else begin
                                mem_a_r     <= '0;
                                addr_vld_p0 <= 1'b0;
                            end
                            // ---- stage p1: capture
                            if (data_vld_p1) begin
                                rbuf    <= put_byte(rbuf, cap_idx[1:0], bus.mem_din);
                                cap_idx <= cap_idx + 3'd1;
                                if (cap_idx == nbytes - 3'd1) begin
                                    state       <= DONE;
                                    data_vld_p1 <= 1'b0;
                                    if (port_ls) begin
                                        ls_rdata_r <= put_byte(rbuf, cap_idx[1:0], bus.mem_din);
                                        ls_done_r  <= 1'b1;
                                    end else begin
                                        if_rdata_r <= put_byte(rbuf, cap_idx[1:0], bus.mem_din);
                                        if_done_r  <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    WRITE: begin
                        // The byte presented last cycle commits at this edge.
                        if (issue_idx < nbytes) begin
                            mem_a_r    <= base + {29'd0, issue_idx};
                            mem_dout_r <= get_byte(wdata, issue_idx[1:0]);
                            issue_idx  <= issue_idx + 3'd1;
                        end else begin
                            state      <= DONE;
                            mem_a_r    <= '0;
                            mem_dout_r <= '0;
                            mem_wr_r   <= 1'b0;
                            ls_done_r  <= port_ls;
                            if_done_r  <= ~port_ls;
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        if_done_r <= 1'b0;
                        ls_done_r <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.mem_a    = mem_a_r;
    assign bus.mem_dout = mem_dout_r;
    assign bus.mem_wr   = mem_wr_r & rdy_in;
    assign bus.if_done  = if_done_r;
    assign bus.ls_done  = ls_done_r;
    assign bus.if_rdata = if_rdata_r;
    assign bus.ls_rdata = ls_rdata_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a byte-array
// reference memory and transfer-level timing rules.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    int          wcount  [logic [31:0]];

    logic [31:0] t_a  [64];
    logic        t_wr [64];
    logic [7:0]  t_d  [64];
    int          done_edge, done_cnt, other_cnt, cnt, ls_edge, if_edge, ls_cnt, if_cnt;
    logic [31:0] got_rdata, last_if, last_ls, wd;
    logic        any_wr;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic int nb(input logic [1:0] s);
        if (s == 2'b00) return 1;
        if (s == 2'b01) return 2;
        return 4;
    endfunction

    // Byte-wide RAM: registered read, write on strobe; HCI drives a random
    // address whenever it owns the bus.
    always @(posedge clk) begin
        if (rdy && bus.mem_wr) begin
            ram[bus.mem_a] = bus.mem_dout;
            wcount[bus.mem_a] = wcount.exists(bus.mem_a) ? wcount[bus.mem_a] + 1 : 1;
        end
        bus.mem_din <= ram_rd(rdy ? bus.mem_a : $urandom());
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        ref_mem[a] = b;
    endtask

    // Run one request; rdy is low during cycle c when mask[c] is set.
    task automatic xfer(input bit ls, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [63:0] mask);
        @(negedge clk);
        if (ls) begin
            bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_size = size;
            bus.ls_addr = addr; bus.ls_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        done_edge = -1; done_cnt = 0; other_cnt = 0;
        @(posedge clk);
        for (int c = 0; c < 64; c++) begin
            #1 rdy = !mask[c];
            #3;
            t_a[c]  = bus.mem_a;
            t_wr[c] = bus.mem_wr;
            t_d[c]  = bus.mem_dout;
            if (ls ? bus.ls_done : bus.if_done) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = c;
                    got_rdata = ls ? bus.ls_rdata : bus.if_rdata;
                end
                if (ls) bus.ls_req = 1'b0; else bus.if_req = 1'b0;
            end
            if (ls ? bus.if_done : bus.ls_done) other_cnt++;
            if (done_edge >= 0 && c >= done_edge + 2) break;
            @(posedge clk);
        end
        rdy = 1'b1;
        bus.ls_req = 1'b0;
        bus.if_req = 1'b0;
    endtask

    task automatic check_xfer(input bit ls, input bit we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input string tag);
        int n;
        logic [31:0] e;
        n = ls ? nb(size) : 4;
        e = '0;
        for (int k = 0; k < n; k++) e[8*k +: 8] = ref_rd(addr + k);
        xfer(ls, we, size, addr, wdata, 64'd0);
        chk({tag, ":done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, ":done_edge"}, 32'(done_edge), we ? 32'(n) : 32'(n + 1));
        chk({tag, ":other_done"}, 32'(other_cnt), 32'd0);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s:addr%0d", tag, k), t_a[k], addr + k);
            chk($sformatf("%s:wr%0d", tag, k), 32'(t_wr[k]), 32'(we));
            if (we) chk($sformatf("%s:dout%0d", tag, k), 32'(t_d[k]), 32'(wdata[8*k +: 8]));
        end
        if (done_edge >= 0) begin
            chk({tag, ":idle_a"}, t_a[done_edge], 32'd0);
            chk({tag, ":idle_wr"}, 32'(t_wr[done_edge]), 32'd0);
        end
        if (!we) begin
            chk({tag, ":rdata"}, got_rdata, e);
            if (ls) begin
                last_ls = e;
                chk({tag, ":if_hold"}, bus.if_rdata, last_if);
            end else begin
                last_if = e;
                chk({tag, ":ls_hold"}, bus.ls_rdata, last_ls);
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                ref_mem[addr + k] = wdata[8*k +: 8];
                chk($sformatf("%s:ram%0d", tag, k), 32'(ram_rd(addr + k)), 32'(wdata[8*k +: 8]));
            end
            chk({tag, ":ls_hold"}, bus.ls_rdata, last_ls);
            chk({tag, ":if_hold"}, bus.if_rdata, last_if);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.if_req = 0; bus.if_addr = 0;
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_size = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
        last_if = 0; last_ls = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst:mem_a", bus.mem_a, 32'd0);
        chk("rst:mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst:mem_dout", 32'(bus.mem_dout), 32'd0);
        chk("rst:if_done", 32'(bus.if_done), 32'd0);
        chk("rst:ls_done", 32'(bus.ls_done), 32'd0);
        chk("rst:if_rdata", bus.if_rdata, 32'd0);
        chk("rst:ls_rdata", bus.ls_rdata, 32'd0);
        @(negedge clk) rst = 1'b0;

        // Instruction fetch of 13 00 00 93
        preload(32'h10, 8'h13); preload(32'h11, 8'h00);
        preload(32'h12, 8'h00); preload(32'h13, 8'h93);
        check_xfer(0, 0, 2'b10, 32'h10, 32'd0, "if_fetch");
        chk("if_fetch:word", got_rdata, 32'h93000013);

        // Word write then byte read
        check_xfer(1, 1, 2'b10, 32'h100, 32'hDEADBEEF, "ls_wr");
        check_xfer(1, 0, 2'b00, 32'h102, 32'd0, "ls_rb");
        chk("ls_rb:byte", got_rdata, 32'h000000AD);

        // Simultaneous requests: LS first, IF after DONE plus one idle cycle
        @(negedge clk);
        bus.if_req = 1; bus.if_addr = 32'h10;
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_size = 2'b10; bus.ls_addr = 32'h100;
        ls_edge = -1; if_edge = -1; ls_cnt = 0; if_cnt = 0;
        @(posedge clk);
        for (int c = 0; c < 30; c++) begin
            #4;
            if (bus.ls_done) begin ls_cnt++; ls_edge = c; bus.ls_req = 0; last_ls = bus.ls_rdata; end
            if (bus.if_done) begin if_cnt++; if_edge = c; bus.if_req = 0; last_if = bus.if_rdata; end
            @(posedge clk);
        end
        bus.ls_req = 0; bus.if_req = 0;
        chk("both:ls_cnt", 32'(ls_cnt), 32'd1);
        chk("both:if_cnt", 32'(if_cnt), 32'd1);
        chk("both:ls_edge", 32'(ls_edge), 32'd5);
        chk("both:if_edge", 32'(if_edge), 32'd12);
        chk("both:ls_rdata", last_ls, 32'hDEADBEEF);
        chk("both:if_rdata", last_if, 32'h93000013);

        // Read paused for three cycles after byte 0 has been captured
        xfer(1, 0, 2'b10, 32'h100, 32'd0, 64'b11100);
        any_wr = 0;
        for (int c = 0; c <= 12; c++) any_wr |= t_wr[c];
        chk("rpause:done_cnt", 32'(done_cnt), 32'd1);
        chk("rpause:done_edge", 32'(done_edge), 32'd10);
        chk("rpause:redrive", t_a[6], 32'h101);
        chk("rpause:word", got_rdata, 32'hDEADBEEF);
        chk("rpause:no_wr", 32'(any_wr), 32'd0);
        last_ls = got_rdata;

        // Write paused while byte 2 is presented
        wcount.delete();
        wd = $urandom();
        xfer(1, 1, 2'b10, 32'h200, wd, 64'b1100);
        chk("wpause:done_edge", 32'(done_edge), 32'd6);
        chk("wpause:wr_paused2", 32'(t_wr[2]), 32'd0);
        chk("wpause:wr_paused3", 32'(t_wr[3]), 32'd0);
        chk("wpause:wr_resume", 32'(t_wr[4]), 32'd1);
        chk("wpause:a_resume", t_a[4], 32'h202);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wpause:count%0d", k),
                32'(wcount.exists(32'h200 + k) ? wcount[32'h200 + k] : 0), 32'd1);
            chk($sformatf("wpause:ram%0d", k), 32'(ram_rd(32'h200 + k)), 32'(wd[8*k +: 8]));
            ref_mem[32'h200 + k] = wd[8*k +: 8];
        end
        chk("wpause:ls_hold", bus.ls_rdata, last_ls);

        // Reset in the middle of a read
        @(negedge clk);
        bus.if_req = 1; bus.if_addr = 32'h10;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("rstmid:busy", bus.mem_a, 32'h12);
        #1 rst = 1'b1;
        #1;
        chk("rstmid:mem_a", bus.mem_a, 32'd0);
        chk("rstmid:mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rstmid:if_rdata", bus.if_rdata, 32'd0);
        chk("rstmid:ls_rdata", bus.ls_rdata, 32'd0);
        chk("rstmid:if_done", 32'(bus.if_done), 32'd0);
        bus.if_req = 0;
        last_if = 0; last_ls = 0;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.if_done || bus.ls_done) cnt++;
        end
        chk("rstmid:no_done", 32'(cnt), 32'd0);
        check_xfer(0, 0, 2'b10, 32'h10, 32'd0, "rstmid:fresh");

        // Halfword read wrapping past the top of the address space
        preload(32'hFFFFFFFF, 8'hA5); preload(32'h0, 8'h3C);
        check_xfer(1, 0, 2'b01, 32'hFFFFFFFF, 32'd0, "wrap");
        chk("wrap:half", got_rdata, 32'h00003CA5);

        // Randomized mix of requests
        for (int t = 0; t < 24; t++) begin
            bit          ls, we;
            logic [1:0]  sz;
            logic [31:0] a;
            ls = ($urandom_range(0, 2) != 0);
            we = ls && $urandom_range(0, 1);
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'h400 + $urandom_range(0, 23);
            check_xfer(ls, we, sz, a, $urandom(), $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
